retire_commit: RTL and testbench
================================

# retire_commit

In-order retirement stage for the 2-wide out-of-order core, and the other end of the rename stage. Each cycle it retires up to two completed instructions from the ROB head. For each retiring instruction it updates the architectural (retirement) RAT and returns the superseded physical register (`p_old_rd`) to the free pool. On an exception at the head it flushes the machine, walks the architectural RAT back into the speculative RAT, and rebuilds the free pool.

## Interface
Parameters:
- `NUM_PHYSICAL_REGISTERS`, 64, physical register count; p0 is permanently mapped to x0 and is never freed.
- `RECOVER_LANES`, 4, architectural RAT entries restored per recovery cycle; must divide 32.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `head0_valid`, `head1_valid` in 1: ROB head / head+1 entry is occupied.
- `head0_done`, `head1_done` in 1: entry has completed execution.
- `head0_exception`, `head1_exception` in 1: entry raised an exception.
- `head0_rd`, `head1_rd` in 5: architectural destination register.
- `head0_p_rd`, `head1_p_rd` in 6: physical destination assigned at rename.
- `head0_p_old_rd`, `head1_p_old_rd` in 6: previous mapping of rd, assigned at rename.
- `commit_count` out 2: entries the ROB pops this cycle (0–2); combinational.
- `free_mask` out `NUM_PHYSICAL_REGISTERS`: one-cycle pulse of registers returned to the free pool; registered.
- `arch_rat[0:31]` out 6 each: architectural RAT; registered.
- `flush` out 1: one-cycle pulse that squashes the front end, ROB and rename state.
- `recover_rat_we` out 1: speculative-RAT restore write enable.
- `recover_rat_idx` out 5: first architectural index of the restore group.
- `recover_rat_data[0:RECOVER_LANES-1]` out 6 each: mappings for indices idx..idx+LANES-1.
- `recover_done` out 1: one-cycle pulse; `recover_free_pool` is valid from this cycle.
- `recover_free_pool` out `NUM_PHYSICAL_REGISTERS`: rebuilt free pool; holds until the next recovery.

## Operation
- States: `RUN`, `WALK`, `DONE`.
- In `RUN`:
  - c0 = `head0_valid & head0_done & ~head0_exception`.
  - c1 = c0 & `head1_valid & head1_done & ~head1_exception`.
  - Retirement is strictly in order: head1 never retires without head0.
  - `commit_count` = c0 + c1.
- For each committing slot with rd != 0:
  - `arch_rat[rd]` <= `p_rd`.
  - Set bit `p_old_rd` of `free_mask`.
  - rd == 0 slots retire but write and free nothing.
- If both slots write the same rd, slot1's `p_rd` wins in `arch_rat`, and both `p_old_rd` values are freed.
- `free_mask` bit 0 is forced to 0 regardless of inputs.
- Exception:
  - If `head0_valid & head0_done & head0_exception`, nothing retires and `commit_count` = 0; next state is `WALK`.
  - If the exception is on head1 only, head0 retires normally; head1 becomes head0 the next cycle and triggers recovery then.
- `WALK` lasts 32/`RECOVER_LANES` cycles, group counter k = 0..N-1:
  - `recover_rat_we` = 1, `recover_rat_idx` = k·LANES, data = `arch_rat[k·LANES + j]`.
  - A used mask accumulates every emitted mapping.
  - `commit_count` = 0 and `free_mask` = 0 for the whole walk; `arch_rat` is frozen.
- `DONE`, one cycle:
  - `recover_done` = 1.
  - `recover_free_pool` = ~used with bit 0 forced to 0.
  - No commits; next state is `RUN`.
- Reset: state `RUN`, `arch_rat[i]` = i, `free_mask` = 0, `flush` = 0, `recover_rat_we` = 0, `recover_done` = 0, `recover_free_pool` = {all ones in bits 32..63, zeros in 0..31}, group counter 0.
- `rst_n` asserted mid-walk aborts the walk: no `recover_done`, and all outputs take their reset values.

## Timing
- Commit at cycle T: `commit_count` is valid in T; `arch_rat` and `free_mask` update at the T→T+1 edge; `free_mask` is high during T+1 only.
- Exception seen in cycle T:
  - `flush` is high in T+1 only.
  - `WALK` runs T+1..T+8 for LANES = 4.
  - `DONE` and `recover_done` occur in T+9.
  - First possible commit is in T+10.
- The ROB inputs are ignored during `WALK` and `DONE`.
- `commit_count` is a pure function of the head inputs and the state, with no added latency.

## Structure
- Shared package `rename_pkg`:
  - `NUM_ARCH_REGS` = 32, `PREG_W` = 6, `preg_t` / `areg_t` typedefs.
  - `rob_head_t` struct (valid, done, exception, rd, p_rd, p_old_rd).
  - `retire_state_e` enum.
  - The rename stage shares the same package.
- One sub-module, `rat_walker`: the group counter, restore outputs and used-mask accumulation. It takes `start` and `arch_rat`, and returns `we`, `idx`, `data`, `last` and `free_pool`.

## Test plan
- Reset, then idle: `arch_rat[5]` = 5, `free_mask` = 0, `recover_free_pool` = 0xFFFFFFFF_00000000, `commit_count` = 0.
- head0 {rd=3, p_rd=40, p_old=3, done}, head1 {rd=7, p_rd=41, p_old=7, done} → `commit_count` = 2; next cycle `arch_rat[3]` = 40, `arch_rat[7]` = 41, `free_mask` = bits 3 and 7, for one cycle only.
- head0 done, head1 not done → `commit_count` = 1; head0 not done, head1 done → `commit_count` = 0.
- Same rd on both slots: head0 {rd=4, p_rd=42, p_old=4}, head1 {rd=4, p_rd=43, p_old=42} → `arch_rat[4]` = 43, `free_mask` = bits 4 and 42.
- head0 rd=0 with p_old_rd=0 → `commit_count` = 1, `free_mask` = 0, `arch_rat` unchanged.
- After the commit above, raise an exception on head0 at T:
  - `flush` pulse in T+1.
  - 8 restore writes with idx 0, 4, …, 28; the first group's data is {0, 1, 2, 40}.
  - `recover_done` in T+9, with a free pool where bits 40 and 41 are 0 and bits 3 and 7 are 1.
  - Asserting `rst_n` in T+4 instead yields no `recover_done` and reset outputs.

Source files
------------

// File: rtl/rename_pkg.sv
// Types shared by the rename and retire stages of the 2-wide core.
package rename_pkg;

    localparam int NUM_ARCH_REGS = 32;
    localparam int AREG_W        = 5;
    localparam int PREG_W        = 6;

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [AREG_W-1:0] areg_t;

    // One ROB head slot as seen by retirement.
    typedef struct packed {
        logic  valid;
        logic  done;
        logic  exception;
        areg_t rd;
        preg_t p_rd;
        preg_t p_old_rd;
    } rob_head_t;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } retire_state_e;

endpackage

// File: rtl/retire_commit_if.sv
// Bundle between the ROB head / rename side and the retirement stage.
interface retire_commit_if
    import rename_pkg::*;
#(
    parameter int NUM_PHYSICAL_REGISTERS = 64,
    parameter int RECOVER_LANES          = 4
);
    rob_head_t                         head0;
    rob_head_t                         head1;
    logic [1:0]                        commit_count;
    logic [NUM_PHYSICAL_REGISTERS-1:0] free_mask;
    preg_t                             arch_rat [NUM_ARCH_REGS];
    logic                              flush;
    logic                              recover_rat_we;
    areg_t                             recover_rat_idx;
    preg_t                             recover_rat_data [RECOVER_LANES];
    logic                              recover_done;
    logic [NUM_PHYSICAL_REGISTERS-1:0] recover_free_pool;

    // ROB / rename side: presents the head entries, consumes retirement results.
    modport master (
        output head0, head1,
        input  commit_count, free_mask, arch_rat, flush, recover_rat_we,
               recover_rat_idx, recover_rat_data, recover_done, recover_free_pool
    );

    // Retirement stage side.
    modport slave (
        input  head0, head1,
        output commit_count, free_mask, arch_rat, flush, recover_rat_we,
               recover_rat_idx, recover_rat_data, recover_done, recover_free_pool
    );
endinterface

// File: rtl/rat_walker.sv
// Streams the architectural RAT into the speculative RAT a group at a time
// and rebuilds the free pool from every mapping it emitted.
module rat_walker
    import rename_pkg::*;
#(
    parameter int NUM_PHYSICAL_REGISTERS = 64,
    parameter int RECOVER_LANES          = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  preg_t                             arch_rat [NUM_ARCH_REGS],
    output logic                              we,
    output areg_t                             idx,
    output preg_t                             data [RECOVER_LANES],
    output logic                              last,
    output logic [NUM_PHYSICAL_REGISTERS-1:0] free_pool
);
    localparam int NP      = NUM_PHYSICAL_REGISTERS;
    localparam int NGROUPS = NUM_ARCH_REGS / RECOVER_LANES;
    localparam int K_W     = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
    // Reset pool: every register above the 32 initial identity mappings is free.
    localparam logic [NP-1:0] POOL_RST = {{(NP-32){1'b1}}, 32'b0};

    logic           active_q;
    logic [K_W-1:0] k_q;
    logic [NP-1:0]  used_q;
    logic [NP-1:0]  pool_q;
    logic [NP-1:0]  group_mask;

    assign we        = active_q;
    assign idx       = areg_t'(int'(k_q) * RECOVER_LANES);
    assign last      = active_q && (k_q == K_W'(NGROUPS - 1));
    assign free_pool = pool_q;

    // One restore lane per generated slot; the RAT is frozen during the walk.
    for (genvar gi = 0; gi < RECOVER_LANES; gi++) begin : g_lane
        assign data[gi] = arch_rat[areg_t'(int'(k_q) * RECOVER_LANES + gi)];
    end

    // Physical registers named by the group currently being emitted.
    always_comb begin
        group_mask = '0;
        for (int j = 0; j < RECOVER_LANES; j++) begin
            group_mask = group_mask | (NP'(1) << data[j]);
        end
    end

    // Group counter, used-mask accumulation and free-pool capture on the last group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            k_q      <= '0;
            used_q   <= '0;
            pool_q   <= POOL_RST;
        end else if (start) begin
            active_q <= 1'b1;
            k_q      <= '0;
            used_q   <= '0;
        end else if (active_q) begin
            used_q <= used_q | group_mask;
            k_q    <= k_q + K_W'(1);
            if (last) begin
                active_q <= 1'b0;
                k_q      <= '0;
                // p0 is hard-wired to x0 and never enters the pool.
                pool_q   <= ~(used_q | group_mask) & ~NP'(1);
            end
        end
    end

endmodule

// File: rtl/retire_commit.sv
// In-order 2-wide retirement: updates the architectural RAT, frees superseded
// physical registers, and on a head exception flushes and restores rename state.
module retire_commit
    import rename_pkg::*;
#(
    parameter int NUM_PHYSICAL_REGISTERS = 64,
    parameter int RECOVER_LANES          = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    retire_commit_if.slave  bus
);
    localparam int NP = NUM_PHYSICAL_REGISTERS;

    retire_state_e state_q, state_d;
    preg_t         arch_rat_q [NUM_ARCH_REGS];
    preg_t         arch_rat_d [NUM_ARCH_REGS];
    logic [NP-1:0] free_mask_q, free_mask_d;
    logic          flush_q;
    logic          c0, c1, exc0, walk_start, walk_last;

    assign bus.arch_rat     = arch_rat_q;
    assign bus.free_mask    = free_mask_q;
    assign bus.flush        = flush_q;
    assign bus.recover_done = (state_q == DONE);

    rat_walker #(
        .NUM_PHYSICAL_REGISTERS(NUM_PHYSICAL_REGISTERS),
        .RECOVER_LANES         (RECOVER_LANES)
    ) u_walker (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (walk_start),
        .arch_rat (arch_rat_q),
        .we       (bus.recover_rat_we),
        .idx      (bus.recover_rat_idx),
        .data     (bus.recover_rat_data),
        .last     (walk_last),
        .free_pool(bus.recover_free_pool)
    );

    // Commit decision and next state; ROB inputs only matter in RUN.
    always_comb begin
        state_d          = state_q;
        c0               = 1'b0;
        c1               = 1'b0;
        exc0             = 1'b0;
        walk_start       = 1'b0;
        bus.commit_count = 2'd0;
        case (state_q)
            RUN: begin
                c0   = bus.head0.valid & bus.head0.done & ~bus.head0.exception;
                c1   = c0 & bus.head1.valid & bus.head1.done & ~bus.head1.exception;
                exc0 = bus.head0.valid & bus.head0.done & bus.head0.exception;
                bus.commit_count = {1'b0, c0} + {1'b0, c1};
                if (exc0) begin
                    state_d    = WALK;
                    walk_start = 1'b1;
                end
            end
            WALK: begin
                if (walk_last) state_d = DONE;
            end
            DONE: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Architectural RAT and freed-register updates; slot1 applied last so it wins on equal rd.
    always_comb begin
        arch_rat_d  = arch_rat_q;
        free_mask_d = '0;
        if (c0 && (bus.head0.rd != '0)) begin
            arch_rat_d[bus.head0.rd] = bus.head0.p_rd;
            free_mask_d = free_mask_d | (NP'(1) << bus.head0.p_old_rd);
        end
        if (c1 && (bus.head1.rd != '0)) begin
            arch_rat_d[bus.head1.rd] = bus.head1.p_rd;
            free_mask_d = free_mask_d | (NP'(1) << bus.head1.p_old_rd);
        end
        free_mask_d[0] = 1'b0;
    end

    // State, RAT, free pulse and flush pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            free_mask_q <= '0;
            flush_q     <= 1'b0;
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                arch_rat_q[i] <= preg_t'(i);
            end
        end else begin
            state_q     <= state_d;
            free_mask_q <= free_mask_d;
            flush_q     <= walk_start;
            arch_rat_q  <= arch_rat_d;
        end
    end

endmodule

// File: tb/tb_retire_commit.sv
// Directed bench for retire_commit: commits, ordering, same-rd, rd0, recovery walk and reset abort.
module tb_retire_commit;
    import rename_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    retire_commit_if #(.NUM_PHYSICAL_REGISTERS(64), .RECOVER_LANES(4)) bus ();

    retire_commit #(.NUM_PHYSICAL_REGISTERS(64), .RECOVER_LANES(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s value=0x%0h", tag, got);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic rob_head_t mk(input logic v, input logic d, input logic e,
                                     input int rd, input int p, input int po);
        rob_head_t h;
        h.valid     = v;
        h.done      = d;
        h.exception = e;
        h.rd        = areg_t'(rd);
        h.p_rd      = preg_t'(p);
        h.p_old_rd  = preg_t'(po);
        return h;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        bus.head0 = '0;
        bus.head1 = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        next_cycle();

        // Reset / idle state
        @(negedge clk);
        check_val("rst_arch5", 64'(bus.arch_rat[5]), 64'd5);
        check_val("rst_free", bus.free_mask, 64'h0);
        check_val("rst_pool", bus.recover_free_pool, 64'hFFFF_FFFF_0000_0000);
        check_val("rst_cc", 64'(bus.commit_count), 64'd0);
        check_val("rst_flush", 64'(bus.flush), 64'd0);
        next_cycle();

        // Dual commit
        bus.head0 = mk(1, 1, 0, 3, 40, 3);
        bus.head1 = mk(1, 1, 0, 7, 41, 7);
        @(negedge clk);
        check_val("dual_cc", 64'(bus.commit_count), 64'd2);
        next_cycle();
        bus.head0 = '0;
        bus.head1 = '0;
        check_val("dual_arch3", 64'(bus.arch_rat[3]), 64'd40);
        check_val("dual_arch7", 64'(bus.arch_rat[7]), 64'd41);
        check_val("dual_free", bus.free_mask, 64'h88);
        next_cycle();
        check_val("dual_free_pulse", bus.free_mask, 64'h0);

        // In-order gating
        bus.head0 = mk(1, 1, 0, 0, 0, 0);
        bus.head1 = mk(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_val("h0only_cc", 64'(bus.commit_count), 64'd1);
        next_cycle();
        bus.head0 = mk(1, 0, 0, 0, 0, 0);
        bus.head1 = mk(1, 1, 0, 0, 0, 0);
        @(negedge clk);
        check_val("h1only_cc", 64'(bus.commit_count), 64'd0);
        next_cycle();

        // Same rd on both slots
        bus.head0 = mk(1, 1, 0, 4, 42, 4);
        bus.head1 = mk(1, 1, 0, 4, 43, 42);
        @(negedge clk);
        check_val("same_cc", 64'(bus.commit_count), 64'd2);
        next_cycle();
        bus.head0 = '0;
        bus.head1 = '0;
        check_val("same_arch4", 64'(bus.arch_rat[4]), 64'd43);
        check_val("same_free", bus.free_mask, 64'h0000_0400_0000_0010);

        // Exception on head1 only: head0 still retires
        bus.head0 = mk(1, 1, 0, 9, 44, 9);
        bus.head1 = mk(1, 1, 1, 12, 45, 12);
        @(negedge clk);
        check_val("h1exc_cc", 64'(bus.commit_count), 64'd1);
        next_cycle();
        bus.head0 = '0;
        bus.head1 = '0;
        check_val("h1exc_arch9", 64'(bus.arch_rat[9]), 64'd44);
        check_val("h1exc_arch12", 64'(bus.arch_rat[12]), 64'd12);
        check_val("h1exc_free", bus.free_mask, 64'h200);
        check_val("h1exc_flush", 64'(bus.flush), 64'd0);

        // rd0 commit frees nothing
        bus.head0 = mk(1, 1, 0, 0, 0, 0);
        @(negedge clk);
        check_val("rd0_cc", 64'(bus.commit_count), 64'd1);
        next_cycle();
        bus.head0 = '0;
        check_val("rd0_free", bus.free_mask, 64'h0);
        check_val("rd0_arch0", 64'(bus.arch_rat[0]), 64'd0);
        next_cycle();

        // Exception on head0 at T; ROB inputs driven with commits during the walk
        bus.head0 = mk(1, 1, 1, 5, 46, 5);
        @(negedge clk);
        check_val("exc_cc", 64'(bus.commit_count), 64'd0);
        next_cycle();
        bus.head0 = mk(1, 1, 0, 6, 47, 6);
        bus.head1 = mk(1, 1, 0, 8, 48, 8);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_val($sformatf("walk%0d_we", k), 64'(bus.recover_rat_we), 64'd1);
            check_val($sformatf("walk%0d_idx", k), 64'(bus.recover_rat_idx), 64'(4 * k));
            check_val($sformatf("walk%0d_cc", k), 64'(bus.commit_count), 64'd0);
            check_val($sformatf("walk%0d_flush", k), 64'(bus.flush), (k == 0) ? 64'd1 : 64'd0);
            check_val($sformatf("walk%0d_done", k), 64'(bus.recover_done), 64'd0);
            if (k == 0) begin
                check_val("walk0_d0", 64'(bus.recover_rat_data[0]), 64'd0);
                check_val("walk0_d1", 64'(bus.recover_rat_data[1]), 64'd1);
                check_val("walk0_d2", 64'(bus.recover_rat_data[2]), 64'd2);
                check_val("walk0_d3", 64'(bus.recover_rat_data[3]), 64'd40);
            end
            next_cycle();
        end
        @(negedge clk);
        check_val("rdone_done", 64'(bus.recover_done), 64'd1);
        check_val("rdone_we", 64'(bus.recover_rat_we), 64'd0);
        check_val("rdone_cc", 64'(bus.commit_count), 64'd0);
        check_val("rdone_pool", bus.recover_free_pool, 64'hFFFF_E4FF_0000_0298);
        check_val("rdone_arch6", 64'(bus.arch_rat[6]), 64'd6);
        next_cycle();
        @(negedge clk);
        check_val("post_done", 64'(bus.recover_done), 64'd0);
        check_val("post_cc", 64'(bus.commit_count), 64'd2);
        check_val("post_pool_hold", bus.recover_free_pool, 64'hFFFF_E4FF_0000_0298);
        bus.head0 = '0;
        bus.head1 = '0;
        next_cycle();

        // Second exception, reset asserted in T+4 aborts the walk
        bus.head0 = mk(1, 1, 1, 5, 46, 5);
        next_cycle();
        bus.head0 = '0;
        repeat (3) next_cycle();
        rst_n = 1'b0;
        #1;
        check_val("abort_we", 64'(bus.recover_rat_we), 64'd0);
        check_val("abort_flush", 64'(bus.flush), 64'd0);
        check_val("abort_arch3", 64'(bus.arch_rat[3]), 64'd3);
        check_val("abort_pool", bus.recover_free_pool, 64'hFFFF_FFFF_0000_0000);
        check_val("abort_free", bus.free_mask, 64'h0);
        repeat (2) next_cycle();
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.recover_done || bus.recover_rat_we) seen++;
        end
        check_val("abort_no_done", 64'(seen), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
